bsearch_engine: RTL and testbench

BSEARCH_ENGINE -- requirements
Module: bsearch_engine

---
 rtl/bsearch_pkg.sv | 6 +
 rtl/bsearch_datapath.sv | 67 ++++++
 rtl/bsearch_engine.sv | 84 ++++++++
 tb/tb_bsearch_engine.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bsearch_pkg.sv
// bsearch_pkg: shared FSM state type and search-mode encodings for the binary search engine
package bsearch_pkg;
  typedef enum logic [1:0] {IDLE, READ, CMP, DONE} state_t;
  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LB = 1'b1;
endpackage

// File: rtl/bsearch_datapath.sv
// bsearch_datapath: lo/hi/mid/cand/probes registers and the key comparator for the binary search
module bsearch_datapath
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic                          enter_cmp,
  input  logic                          cmp,
  input  logic [DATA_W-1:0]             key,
  input  logic                          mode,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [ADDR_W-1:0]             mid,
  output logic                          fin,
  output logic                          res_found,
  output logic [ADDR_W-1:0]             res_addr,
  output logic [$clog2(ADDR_W+2)-1:0]   probes
);
  logic [ADDR_W:0] lo, hi, mid_w;
  logic [DATA_W-1:0] key_q;
  logic mode_q, cand_v, lt, eq, empty;
  logic [ADDR_W-1:0] cand;
  // Midpoint, comparison and the outcome of finishing on the current probe.
  // Since lo <= mid <= hi while searching, new lo > new hi reduces to mid hitting
  // the bound that is being moved past, which also sidesteps hi = mid-1 wrapping at mid=0.
  always_comb begin
    mid_w = (lo + hi) >> 1;
    mid = mid_w[ADDR_W-1:0];
    lt = mem_rdata < key_q;
    eq = mem_rdata == key_q;
    empty = lt ? mid_w == hi : mid_w == lo;
    fin = (mode_q == MODE_EXACT && eq) || empty;
    res_found = mode_q == MODE_LB ? (cand_v || !lt) : eq;
    res_addr = mode_q == MODE_LB ? (lt ? cand : mid) : (eq ? mid : '0);
  end
  // Search window, lower-bound candidate and probe counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo <= '0;
      hi <= '0;
      key_q <= '0;
      mode_q <= MODE_EXACT;
      cand <= '0;
      cand_v <= 1'b0;
      probes <= '0;
    end else if (init) begin
      lo <= '0;
      hi <= {1'b0, {ADDR_W{1'b1}}};
      key_q <= key;
      mode_q <= mode;
      cand <= '0;
      cand_v <= 1'b0;
      probes <= '0;
    end else begin
      if (enter_cmp) probes <= probes + 1'b1;
      if (cmp && lt) lo <= mid_w + 1'b1;
      if (cmp && !lt) hi <= mid_w - 1'b1;
      if (cmp && !lt && mode_q == MODE_LB) begin
        cand <= mid;
        cand_v <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/bsearch_engine.sv
// bsearch_engine: binary search over an external sorted read-only RAM, exact or lower-bound match
module bsearch_engine
  import bsearch_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DATA_W-1:0]             key,
  input  logic                          mode,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [ADDR_W-1:0]             result_addr,
  output logic [$clog2(ADDR_W+2)-1:0]   probes
);
  state_t state;
  logic [2:0] rd_cnt;
  logic init, enter_cmp, in_cmp, fin, res_found;
  logic [ADDR_W-1:0] res_addr;
  assign init = state == IDLE && start;
  assign enter_cmp = state == READ && rd_cnt == 3'(RD_LAT - 1);
  assign in_cmp = state == CMP;
  bsearch_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dp (
    .clk(clk),
    .reset(reset),
    .init(init),
    .enter_cmp(enter_cmp),
    .cmp(in_cmp),
    .key(key),
    .mode(mode),
    .mem_rdata(mem_rdata),
    .mid(mem_addr),
    .fin(fin),
    .res_found(res_found),
    .res_addr(res_addr),
    .probes(probes)
  );
  // Control FSM: waits RD_LAT cycles per read, then compares and either reprobes or finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rd_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      found <= 1'b0;
      result_addr <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= READ;
          rd_cnt <= '0;
          busy <= 1'b1;
          found <= 1'b0;
          result_addr <= '0;
        end
        READ: begin
          state <= enter_cmp ? CMP : READ;
          rd_cnt <= rd_cnt + 3'd1;
        end
        CMP: if (fin) begin
          state <= DONE;
          done <= 1'b1;
          found <= res_found;
          result_addr <= res_addr;
        end else begin
          state <= READ;
          rd_cnt <= '0;
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bsearch_engine.sv
// tb_bsearch_engine: directed and random searches against a sorted RAM model
module tb_bsearch_engine;
  localparam int DEPTH = 32;
  localparam int RL = 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [7:0] key = '0;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr, result_addr;
  logic busy, done, found;
  logic [2:0] probes;
  logic [7:0] ram [DEPTH];
  int total = 0;
  int bad = 0;

  bsearch_engine #(.DATA_W(8), .ADDR_W(5), .RD_LAT(RL)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .key(key),
    .mode(mode),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .busy(busy),
    .done(done),
    .found(found),
    .result_addr(result_addr),
    .probes(probes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Result by linear scan; probe count by textbook binary search over integers.
  task automatic model(input logic [7:0] k, input logic m, output logic f, output int a, output int p);
    int lo, hi, md;
    f = 1'b0;
    a = 0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (m ? ram[i] >= k : ram[i] == k) begin
        f = 1'b1;
        a = i;
      end
    lo = 0;
    hi = DEPTH - 1;
    p = 0;
    while (lo <= hi) begin
      md = (lo + hi) / 2;
      p++;
      if (!m && ram[md] == k) break;
      if (ram[md] >= k) hi = md - 1;
      else lo = md + 1;
    end
  endtask

  task automatic search(input logic [7:0] k, input logic m, input int glitch, input string tag);
    logic ef;
    int ea, ep, cyc;
    model(k, m, ef, ea, ep);
    @(negedge clk);
    key = k;
    mode = m;
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (cyc == glitch);
      if (cyc == glitch) key = ~k;
      if (cyc == 1) chk({tag, ":busy"}, 32'(busy), 1);
    end while (!done && cyc < 200);
    chk({tag, ":latency"}, cyc, ep * (RL + 1) + 1);
    chk({tag, ":found"}, 32'(found), 32'(ef));
    chk({tag, ":addr"}, 32'(result_addr), ea);
    chk({tag, ":probes"}, 32'(probes), ep);
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":pulse"}, {31'd0, done, busy}, 0);
  endtask

  initial begin
    int seen;
    logic [7:0] v;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(2 * i);
    repeat (3) @(negedge clk);
    #1;
    chk("rst:busy", 32'(busy), 0);
    chk("rst:done", 32'(done), 0);
    chk("rst:found", 32'(found), 0);
    chk("rst:addr", 32'(result_addr), 0);
    chk("rst:probes", 32'(probes), 0);
    chk("rst:mem_addr", 32'(mem_addr), 0);
    @(negedge clk) reset = 1'b1;
    search(8'd20, 1'b0, 0, "ex20");
    chk("ex20:const_addr", 32'(result_addr), 10);
    chk("ex20:const_probes", 32'(probes), 5);
    search(8'd62, 1'b0, 0, "ex62");
    chk("ex62:const_probes", 32'(probes), 6);
    search(8'd0, 1'b0, 0, "ex0");
    search(8'd21, 1'b0, 0, "ex21");
    chk("ex21:const_found", 32'(found), 0);
    search(8'd21, 1'b1, 0, "lb21");
    chk("lb21:const_addr", 32'(result_addr), 11);
    search(8'd63, 1'b1, 0, "lb63");
    chk("lb63:const_found", 32'(found), 0);
    search(8'd0, 1'b1, 0, "lb0");
    search(8'd20, 1'b0, 3, "glitch");
    chk("glitch:const_addr", 32'(result_addr), 10);
    @(negedge clk);
    key = 8'd40;
    mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort:busy", 32'(busy), 0);
    chk("abort:done", 32'(done), 0);
    chk("abort:found", 32'(found), 0);
    chk("abort:addr", 32'(result_addr), 0);
    chk("abort:probes", 32'(probes), 0);
    chk("abort:mem_addr", 32'(mem_addr), 0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen++;
    end
    reset = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort:no_done", seen, 0);
    search(8'd40, 1'b0, 0, "after_rst");
    for (int t = 0; t < 30; t++) begin
      v = 8'($urandom_range(0, 3));
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] = v;
        v = v + 8'($urandom_range(1, 6));
      end
      v = t[0] ? ram[$urandom_range(0, DEPTH - 1)] : 8'($urandom_range(0, 255));
      search(v, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", t));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
